// File: rtl/ms_delay_arbiter.sv
// ms_delay_arbiter: shares one 1 ms tick timer between NUM_REQ requesters.
// Round-robin grant, counts ticks down from the winner's delay, stops the timer, pulses done.
module ms_delay_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay_ms,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     timer_enable,
    output logic                     timer_stop,
    input  logic                     timer_tick,
    output logic                     busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               completed_q, completed_d;
    logic               armed_q, armed_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               enable_q, enable_d;
    logic               stop_q, stop_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   sel;
    logic [CNT_W-1:0]   win_delay;
    logic [NUM_REQ-1:0] owner_oh;
    int                 idx;

    // Round-robin search starting just after the last served requester
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            sel = IDX_W'(idx);
            if (!found && req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
        win_delay = delay_ms[int'(winner)*CNT_W +: CNT_W];
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            remaining_q <= '0;
            completed_q <= 1'b0;
            armed_q     <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            enable_q    <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            remaining_q <= remaining_d;
            completed_q <= completed_d;
            armed_q     <= armed_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            enable_q    <= enable_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: arbitration, tick countdown, abort and completion
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        remaining_d = remaining_q;
        completed_d = completed_q;
        armed_d     = armed_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d     = winner;
                    remaining_d = win_delay;
                    if (win_delay == '0) begin
                        // Zero delay passes through STOP with the timer
                        // untouched so grant shows a cycle before done.
                        state_d     = STOP;
                        completed_d = 1'b1;
                        armed_d     = 1'b0;
                    end else begin
                        state_d     = RUN;
                        completed_d = 1'b0;
                        armed_d     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d     = STOP;
                    completed_d = 1'b0;
                end else if (timer_tick) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = STOP;
                        completed_d = 1'b1;
                    end
                end
            end
            STOP: begin
                state_d = completed_q ? DONE : IDLE;
            end
            DONE: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_d] = 1'b1;
        grant_d  = (state_d == RUN || state_d == STOP) ? owner_oh : '0;
        done_d   = (state_d == DONE) ? owner_oh : '0;
        enable_d = (state_d == RUN);
        stop_d   = (state_d == STOP) && armed_d;
        busy_d   = (state_d != IDLE);
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign timer_enable = enable_q;
    assign timer_stop   = stop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ms_delay_arbiter.sv
// tb_ms_delay_arbiter: directed vectors for ms_delay_arbiter.
// Expected values are hand-derived from the cycle timing of each scenario.
module tb_ms_delay_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay_ms;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           timer_enable;
    logic           timer_stop;
    logic           timer_tick;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int order [6] = '{0, 1, 3, 0, 1, 3};

    ms_delay_arbiter #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clock        (clock),
        .rst          (rst),
        .req          (req),
        .delay_ms     (delay_ms),
        .grant        (grant),
        .done         (done),
        .timer_enable (timer_enable),
        .timer_stop   (timer_stop),
        .timer_tick   (timer_tick),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic tick();
        timer_tick = 1'b1;
        cyc();
        timer_tick = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        delay_ms   = '0;
        timer_tick = 1'b0;
        idle(2);
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_en", 32'(timer_enable), 0);
        check("rst_stop", 32'(timer_stop), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        cyc();

        // Spurious tick while idle
        tick();
        check("idle_tick_busy", 32'(busy), 0);
        check("idle_tick_en", 32'(timer_enable), 0);

        // Single request, delay 3, tick every 10 cycles
        req           = 4'b0001;
        delay_ms[7:0] = 8'd3;
        cyc();
        check("s1_grant", 32'(grant), 32'h1);
        check("s1_en", 32'(timer_enable), 1);
        check("s1_busy", 32'(busy), 1);
        delay_ms[7:0] = 8'd9;
        for (int k = 1; k <= 3; k++) begin
            idle(9);
            check("s1_nodone", 32'(done), 0);
            tick();
            if (k < 3) begin
                check("s1_mid_stop", 32'(timer_stop), 0);
                check("s1_mid_en", 32'(timer_enable), 1);
                check("s1_mid_grant", 32'(grant), 32'h1);
            end
        end
        check("s1_stop", 32'(timer_stop), 1);
        check("s1_stop_en", 32'(timer_enable), 0);
        check("s1_stop_done", 32'(done), 0);
        timer_tick = 1'b1;
        cyc();
        timer_tick = 1'b0;
        check("s1_done", 32'(done), 32'h1);
        check("s1_done_grant", 32'(grant), 0);
        check("s1_done_stop", 32'(timer_stop), 0);
        req = '0;
        cyc();
        check("s1_after_done", 32'(done), 0);
        check("s1_after_busy", 32'(busy), 0);

        // Zero delay: no timer activity
        req             = 4'b0100;
        delay_ms[23:16] = 8'd0;
        cyc();
        check("z_grant", 32'(grant), 32'h4);
        check("z_en", 32'(timer_enable), 0);
        check("z_stop", 32'(timer_stop), 0);
        check("z_nodone", 32'(done), 0);
        cyc();
        check("z_done", 32'(done), 32'h4);
        check("z_done_grant", 32'(grant), 0);
        check("z_done_en", 32'(timer_enable), 0);
        check("z_done_stop", 32'(timer_stop), 0);
        req = '0;
        cyc();
        check("z_after_done", 32'(done), 0);
        check("z_after_busy", 32'(busy), 0);

        // Round-robin from a fresh reset
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        delay_ms = {8'd1, 8'd1, 8'd1, 8'd1};
        req      = 4'b1011;
        for (int s = 0; s < 6; s++) begin
            for (int w = 0; w < 10 && grant == '0; w++) cyc();
            check("rr_grant", 32'(grant), 32'(1 << order[s]));
            check("rr_en", 32'(timer_enable), 1);
            tick();
            cyc();
            check("rr_done", 32'(done), 32'(1 << order[s]));
        end
        req = '0;
        idle(2);
        check("rr_end_grant", 32'(grant), 0);
        check("rr_end_busy", 32'(busy), 0);

        // Abort with a tick in the same cycle
        req            = 4'b0010;
        delay_ms[15:8] = 8'd5;
        cyc();
        check("ab_grant", 32'(grant), 32'h2);
        check("ab_en", 32'(timer_enable), 1);
        idle(2);
        tick();
        idle(2);
        tick();
        idle(2);
        req        = '0;
        timer_tick = 1'b1;
        cyc();
        timer_tick = 1'b0;
        check("ab_stop", 32'(timer_stop), 1);
        check("ab_stop_en", 32'(timer_enable), 0);
        check("ab_stop_done", 32'(done), 0);
        cyc();
        check("ab_idle_grant", 32'(grant), 0);
        check("ab_idle_done", 32'(done), 0);
        check("ab_idle_busy", 32'(busy), 0);
        check("ab_idle_stop", 32'(timer_stop), 0);
        cyc();
        check("ab_late_done", 32'(done), 0);

        // Reset in the middle of RUN, then a clean restart
        req           = 4'b0001;
        delay_ms[7:0] = 8'd4;
        cyc();
        check("rm_grant", 32'(grant), 32'h1);
        idle(2);
        tick();
        idle(2);
        rst = 1'b1;
        cyc();
        check("rm_rst_grant", 32'(grant), 0);
        check("rm_rst_en", 32'(timer_enable), 0);
        check("rm_rst_busy", 32'(busy), 0);
        check("rm_rst_done", 32'(done), 0);
        check("rm_rst_stop", 32'(timer_stop), 0);
        rst = 1'b0;
        cyc();
        check("rm_regrant", 32'(grant), 32'h1);
        check("rm_regrant_en", 32'(timer_enable), 1);
        for (int k = 1; k <= 3; k++) begin
            idle(2);
            tick();
            check("rm_mid_stop", 32'(timer_stop), 0);
            check("rm_mid_en", 32'(timer_enable), 1);
        end
        idle(2);
        tick();
        check("rm_stop", 32'(timer_stop), 1);
        cyc();
        check("rm_done", 32'(done), 32'h1);
        req = '0;
        idle(2);
        check("rm_end_busy", 32'(busy), 0);
        check("rm_end_done", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
